// File: rtl/uart_fifo_slave_if.sv
// Pipelined Wishbone bundle between the system bus and uart_fifo_slave.
interface uart_fifo_slave_if;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [3:0]  sel_i;
    logic        we_i;
    logic        cyc_i;
    logic        stb_i;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;
    logic        stall_o;

    modport master (
        output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        input  dat_o, ack_o, err_o, rty_o, stall_o
    );

    modport slave (
        input  adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        output dat_o, ack_o, err_o, rty_o, stall_o
    );
endinterface

// File: rtl/uart_fifo_slave.sv
// Wishbone slave fronting a UART TX/RX pair through two byte FIFOs.
// DATA pops RX / pushes TX, STATUS reports levels and a sticky overrun,
// CTRL holds interrupt enables, the blocking-access mode and the RX threshold.
// In blocking mode a DATA access that cannot complete is parked and the bus
// is stalled until the FIFO condition clears or the master drops cyc_i.
module uart_fifo_slave #(
    parameter int DEPTH_LOG2    = 4,
    parameter int RX_THRESH_RST = 1
) (
    input  logic             clk_bus,
    input  logic             rst_bus,
    uart_fifo_slave_if.slave wb,
    output logic             uart_start,
    output logic [7:0]       uart_dat_o,
    input  logic             uart_busy,
    input  logic             uart_ready,
    input  logic [7:0]       uart_dat_i,
    output logic             irq
);
    localparam int            PW        = DEPTH_LOG2 + 1;
    localparam int            DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [8:0]    DEPTH9    = 9'(DEPTH);
    localparam logic [7:0]    THR_RST   = 8'(RX_THRESH_RST);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO  = PW'(0);

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_LAUNCH = 2'd1,
        TX_GUARD  = 2'd2
    } tx_state_t;

    // Full when the low pointer bits match and the wrap bits differ.
    function automatic logic fifo_full(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
        return (wr[PW-1] != rd[PW-1]) && (wr[PW-2:0] == rd[PW-2:0]);
    endfunction

    // ---------------- storage and state ----------------
    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    tx_mem_q [DEPTH];
    logic [PW-1:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
    logic [PW-1:0] rx_wr_d, rx_rd_d, tx_wr_d, tx_rd_d;

    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   dat_q, dat_d;
    logic          pend_q, pend_d;
    logic          pend_we_q, pend_we_d;
    logic [7:0]    pend_byte_q, pend_byte_d;

    logic          rx_irq_en_q, rx_irq_en_d;
    logic          tx_irq_en_q, tx_irq_en_d;
    logic          blocking_q, blocking_d;
    logic [7:0]    rx_thresh_q, rx_thresh_d;
    logic          ovr_q, ovr_d;
    logic          irq_q, irq_d;

    tx_state_t     tx_state_q;
    logic          uart_start_q;
    logic [7:0]    uart_dat_q;

    // ---------------- derived FIFO status ----------------
    logic [PW-1:0] rx_count_s, tx_count_s;
    logic [8:0]    rx_count9_s, tx_free9_s, thr_eff_s;
    logic          rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
    logic [7:0]    rx_head_s, tx_head_s;
    logic [31:0]   status_s, ctrl_word_s;
    logic          acc_s;
    logic          rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
    logic [7:0]    tx_push_byte_s;
    logic          ovr_clr_s;
    logic          unused_s;

    assign rx_count_s  = rx_wr_q - rx_rd_q;
    assign tx_count_s  = tx_wr_q - tx_rd_q;
    assign rx_count9_s = 9'(rx_count_s);
    assign tx_free9_s  = DEPTH9 - 9'(tx_count_s);
    assign rx_empty_s  = (rx_count_s == PTR_ZERO);
    assign tx_empty_s  = (tx_count_s == PTR_ZERO);
    assign rx_full_s   = fifo_full(rx_wr_q, rx_rd_q);
    assign tx_full_s   = fifo_full(tx_wr_q, tx_rd_q);
    assign rx_head_s   = rx_mem_q[rx_rd_q[PW-2:0]];
    assign tx_head_s   = tx_mem_q[tx_rd_q[PW-2:0]];
    assign thr_eff_s   = (rx_thresh_q == 8'd0) ? 9'd1 : {1'b0, rx_thresh_q};

    assign status_s    = {ovr_q, tx_full_s, rx_empty_s, 4'b0000, tx_free9_s,
                          7'b0000000, rx_count9_s};
    assign ctrl_word_s = {16'h0000, rx_thresh_q, 5'b00000, blocking_q,
                          tx_irq_en_q, rx_irq_en_q};

    // A new request is taken only when no parked access holds the bus.
    assign acc_s       = wb.cyc_i & wb.stb_i & ~pend_q;

    // Received bytes land in RX unless it is full at the start of the cycle.
    assign rx_push_s   = uart_ready & ~rx_full_s;

    // The transmitter drains TX one byte per three cycles when it is free.
    assign tx_pop_s    = (tx_state_q == TX_IDLE) & ~uart_busy & ~tx_empty_s;

    assign wb.ack_o    = ack_q;
    assign wb.err_o    = err_q;
    assign wb.dat_o    = dat_q;
    assign wb.stall_o  = pend_q;
    assign wb.rty_o    = 1'b0;
    assign uart_start  = uart_start_q;
    assign uart_dat_o  = uart_dat_q;
    assign irq         = irq_q;

    // Only adr_i[3:2] is decoded and all accesses are full-word.
    assign unused_s    = ^{wb.sel_i, wb.adr_i[31:4], wb.adr_i[1:0], wb.dat_i[30:16]};

    // Bus decode: serve a parked access first, otherwise the newly accepted one.
    always_comb begin
        ack_d          = 1'b0;
        err_d          = 1'b0;
        dat_d          = dat_q;
        pend_d         = pend_q;
        pend_we_d      = pend_we_q;
        pend_byte_d    = pend_byte_q;
        rx_pop_s       = 1'b0;
        tx_push_s      = 1'b0;
        tx_push_byte_s = wb.dat_i[7:0];
        ovr_clr_s      = 1'b0;
        rx_irq_en_d    = rx_irq_en_q;
        tx_irq_en_d    = tx_irq_en_q;
        blocking_d     = blocking_q;
        rx_thresh_d    = rx_thresh_q;

        if (pend_q) begin
            if (!wb.cyc_i) begin
                pend_d = 1'b0;
            end else if (pend_we_q) begin
                if (!tx_full_s) begin
                    tx_push_s      = 1'b1;
                    tx_push_byte_s = pend_byte_q;
                    ack_d          = 1'b1;
                    pend_d         = 1'b0;
                end else begin
                    pend_d = 1'b1;
                end
            end else begin
                if (!rx_empty_s) begin
                    rx_pop_s = 1'b1;
                    dat_d    = {24'h000000, rx_head_s};
                    ack_d    = 1'b1;
                    pend_d   = 1'b0;
                end else begin
                    pend_d = 1'b1;
                end
            end
        end else if (acc_s) begin
            case (wb.adr_i[3:2])
                2'd0: begin
                    if (wb.we_i) begin
                        if (!tx_full_s) begin
                            tx_push_s = 1'b1;
                            ack_d     = 1'b1;
                        end else if (blocking_q) begin
                            pend_d      = 1'b1;
                            pend_we_d   = 1'b1;
                            pend_byte_d = wb.dat_i[7:0];
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        if (!rx_empty_s) begin
                            rx_pop_s = 1'b1;
                            dat_d    = {24'h000000, rx_head_s};
                            ack_d    = 1'b1;
                        end else if (blocking_q) begin
                            pend_d    = 1'b1;
                            pend_we_d = 1'b0;
                        end else begin
                            dat_d = 32'h8000_0000;
                            ack_d = 1'b1;
                        end
                    end
                end
                2'd1: begin
                    ack_d = 1'b1;
                    if (wb.we_i) begin
                        ovr_clr_s = wb.dat_i[31];
                    end else begin
                        dat_d = status_s;
                    end
                end
                2'd2: begin
                    ack_d = 1'b1;
                    if (wb.we_i) begin
                        rx_irq_en_d = wb.dat_i[0];
                        tx_irq_en_d = wb.dat_i[1];
                        blocking_d  = wb.dat_i[2];
                        rx_thresh_d = wb.dat_i[15:8];
                    end else begin
                        dat_d = ctrl_word_s;
                    end
                end
                2'd3: begin
                    if (wb.we_i) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        dat_d = 32'h0000_0000;
                    end
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end else begin
            pend_d = 1'b0;
        end
    end

    // Pointer, overrun and interrupt next-state from this cycle's FIFO events.
    always_comb begin
        rx_wr_d = rx_wr_q + (rx_push_s ? PTR_ONE : PTR_ZERO);
        rx_rd_d = rx_rd_q + (rx_pop_s  ? PTR_ONE : PTR_ZERO);
        tx_wr_d = tx_wr_q + ((tx_push_s && !tx_full_s) ? PTR_ONE : PTR_ZERO);
        tx_rd_d = tx_rd_q + (tx_pop_s  ? PTR_ONE : PTR_ZERO);
        // A fresh overrun wins over a simultaneous clear.
        ovr_d   = (ovr_q & ~ovr_clr_s) | (uart_ready & rx_full_s);
        irq_d   = (rx_irq_en_q & ((rx_count9_s >= thr_eff_s) | ovr_q)) |
                  (tx_irq_en_q & tx_empty_s);
    end

    // Bus-side registers, FIFO pointers and control/status state.
    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) begin
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= 32'h0000_0000;
            pend_q      <= 1'b0;
            pend_we_q   <= 1'b0;
            pend_byte_q <= 8'h00;
            rx_irq_en_q <= 1'b0;
            tx_irq_en_q <= 1'b0;
            blocking_q  <= 1'b0;
            rx_thresh_q <= THR_RST;
            ovr_q       <= 1'b0;
            irq_q       <= 1'b0;
            rx_wr_q     <= PTR_ZERO;
            rx_rd_q     <= PTR_ZERO;
            tx_wr_q     <= PTR_ZERO;
            tx_rd_q     <= PTR_ZERO;
        end else begin
            ack_q       <= ack_d;
            err_q       <= err_d;
            dat_q       <= dat_d;
            pend_q      <= pend_d;
            pend_we_q   <= pend_we_d;
            pend_byte_q <= pend_byte_d;
            rx_irq_en_q <= rx_irq_en_d;
            tx_irq_en_q <= tx_irq_en_d;
            blocking_q  <= blocking_d;
            rx_thresh_q <= rx_thresh_d;
            ovr_q       <= ovr_d;
            irq_q       <= irq_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
        end
    end

    // FIFO storage writes; contents need no reset since pointers gate them.
    always_ff @(posedge clk_bus) begin
        if (rx_push_s) begin
            rx_mem_q[rx_wr_q[PW-2:0]] <= uart_dat_i;
        end
        if (tx_push_s && !tx_full_s) begin
            tx_mem_q[tx_wr_q[PW-2:0]] <= tx_push_byte_s;
        end
    end

    // Transmit engine: pop, strobe start with the byte, then allow busy to rise.
    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) begin
            tx_state_q   <= TX_IDLE;
            uart_start_q <= 1'b0;
            uart_dat_q   <= 8'h00;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_pop_s) begin
                        uart_dat_q   <= tx_head_s;
                        uart_start_q <= 1'b1;
                        tx_state_q   <= TX_LAUNCH;
                    end else begin
                        uart_start_q <= 1'b0;
                    end
                end
                TX_LAUNCH: begin
                    uart_start_q <= 1'b0;
                    tx_state_q   <= TX_GUARD;
                end
                TX_GUARD: begin
                    uart_start_q <= 1'b0;
                    tx_state_q   <= TX_IDLE;
                end
                default: begin
                    uart_start_q <= 1'b0;
                    tx_state_q   <= TX_IDLE;
                end
            endcase
        end
    end
endmodule
